// File: rtl/oam_dma_controller.sv
// OAM DMA sequencer: halts the CPU, then copies one page of CPU memory to the
// PPU OAMDATA port as GET-aligned read/write pairs.
module oam_dma_controller #(
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int          TRANSFER_LEN  = 256
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_ce,
    input  logic        i_dma_start,
    input  logic [7:0]  i_dma_page,
    input  logic        i_cpu_halted,
    input  logic [7:0]  i_bus_data,
    output logic        o_cpu_rdy,
    output logic        o_bus_request,
    output logic [15:0] o_bus_address,
    output logic        o_bus_rw,
    output logic [7:0]  o_bus_data,
    output logic        o_busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(TRANSFER_LEN - 1);

    state_t      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  index_q, index_d;
    logic        parity_q, parity_d;
    logic [7:0]  data_q, data_d;
    logic        rdy_q, rdy_d;
    logic        req_q, req_d;
    logic [15:0] addr_q, addr_d;
    logic        rw_q, rw_d;
    logic        busy_q, busy_d;

    // Next-state logic; bus outputs are derived from the next state so they are registered
    always_comb begin
        state_d  = state_q;
        page_d   = page_q;
        index_d  = index_q;
        parity_d = parity_q;
        data_d   = data_q;
        rdy_d    = rdy_q;
        req_d    = req_q;
        addr_d   = addr_q;
        rw_d     = rw_q;
        busy_d   = busy_q;
        if (i_ce) begin
            parity_d = ~parity_q;
            case (state_q)
                S_IDLE: begin
                    if (i_dma_start) begin
                        page_d  = i_dma_page;
                        index_d = 8'd0;
                        state_d = S_HALT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_HALT: begin
                    // Parity 1 now means the following cycle is a GET, so reads can start
                    if (i_cpu_halted) begin
                        if (parity_q) begin
                            state_d = S_READ;
                        end else begin
                            state_d = S_ALIGN;
                        end
                    end else begin
                        state_d = S_HALT;
                    end
                end
                S_ALIGN: state_d = S_READ;
                S_READ: begin
                    data_d  = i_bus_data;
                    state_d = S_WRITE;
                end
                S_WRITE: begin
                    if (index_q == LAST_IDX) begin
                        state_d = S_IDLE;
                    end else begin
                        index_d = index_q + 8'd1;
                        state_d = S_READ;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            case (state_d)
                S_IDLE: begin
                    rdy_d  = 1'b1;
                    busy_d = 1'b0;
                    req_d  = 1'b0;
                    rw_d   = 1'b1;
                    addr_d = 16'h0000;
                end
                S_HALT, S_ALIGN: begin
                    rdy_d  = 1'b0;
                    busy_d = 1'b1;
                    req_d  = 1'b0;
                    rw_d   = 1'b1;
                    addr_d = 16'h0000;
                end
                S_READ: begin
                    rdy_d  = 1'b0;
                    busy_d = 1'b1;
                    req_d  = 1'b1;
                    rw_d   = 1'b1;
                    addr_d = {page_d, index_d};
                end
                S_WRITE: begin
                    rdy_d  = 1'b0;
                    busy_d = 1'b1;
                    req_d  = 1'b1;
                    rw_d   = 1'b0;
                    addr_d = OAM_DATA_ADDR;
                end
                default: begin
                    rdy_d  = 1'b1;
                    busy_d = 1'b0;
                    req_d  = 1'b0;
                    rw_d   = 1'b1;
                    addr_d = 16'h0000;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= S_IDLE;
            page_q   <= 8'd0;
            index_q  <= 8'd0;
            parity_q <= 1'b0;
            data_q   <= 8'd0;
            rdy_q    <= 1'b1;
            req_q    <= 1'b0;
            addr_q   <= 16'h0000;
            rw_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            index_q  <= index_d;
            parity_q <= parity_d;
            data_q   <= data_d;
            rdy_q    <= rdy_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            rw_q     <= rw_d;
            busy_q   <= busy_d;
        end
    end

    assign o_cpu_rdy     = rdy_q;
    assign o_bus_request = req_q;
    assign o_bus_address = addr_q;
    assign o_bus_rw      = rw_q;
    assign o_bus_data    = data_q;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed bench for oam_dma_controller: a behavioural memory answers reads and
// each scenario task checks cycle counts, bus sequence and byte values.
module tb_oam_dma_controller;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_ce = 1'b0;
    logic        i_dma_start = 1'b0;
    logic [7:0]  i_dma_page = 8'h00;
    logic        i_cpu_halted = 1'b1;
    logic [7:0]  i_bus_data;
    logic        o_cpu_rdy;
    logic        o_bus_request;
    logic [15:0] o_bus_address;
    logic        o_bus_rw;
    logic [7:0]  o_bus_data;
    logic        o_busy;

    int   checks = 0;
    int   failures = 0;
    logic par = 1'b0;
    logic [27:0] outs;

    always #5 i_clk = ~i_clk;

    oam_dma_controller dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_ce          (i_ce),
        .i_dma_start   (i_dma_start),
        .i_dma_page    (i_dma_page),
        .i_cpu_halted  (i_cpu_halted),
        .i_bus_data    (i_bus_data),
        .o_cpu_rdy     (o_cpu_rdy),
        .o_bus_request (o_bus_request),
        .o_bus_address (o_bus_address),
        .o_bus_rw      (o_bus_rw),
        .o_bus_data    (o_bus_data),
        .o_busy        (o_busy)
    );

    function automatic logic [7:0] mem_val(input logic [15:0] a);
        logic [7:0] t;
        t = a[7:0] * 8'd3;
        return t ^ a[15:8] ^ 8'h5A;
    endfunction

    assign i_bus_data = mem_val(o_bus_address);
    assign outs = {o_cpu_rdy, o_bus_request, o_bus_address, o_bus_rw, o_bus_data, o_busy};

    task automatic tick();
        @(posedge i_clk);
        if (i_ce) par = ~par;
        @(negedge i_clk);
    endtask

    // Runs one transfer; want_par is the parity of the first HALT cycle.
    task automatic run_xfer(input logic [7:0] page, input logic want_par, input int halt_wait,
                            input int ce_div, input int glitch_idx, input int reset_idx,
                            output int rdy_low, output int no_req_low, output int nbytes,
                            output int seq_err, output int hold_err, output logic [27:0] rsnap);
        int cyc = 0, hcnt = 0, idx = 0;
        bit started = 0, seen_low = 0, done = 0, exp_read = 1, ce_now;
        logic [27:0] prev;
        rdy_low = 0; no_req_low = 0; nbytes = 0; seq_err = 0; hold_err = 0; rsnap = '1;
        i_cpu_halted = (halt_wait == 0);
        for (int k = 0; k < 12 && !started; k++) begin
            i_ce = ((cyc % ce_div) == 0);
            cyc++;
            if (i_ce && par == !want_par) begin
                i_dma_start = 1'b1;
                i_dma_page  = page;
                started = 1;
            end
            tick();
        end
        i_dma_start = 1'b0;
        i_dma_page  = 8'hEE;
        if (!started) seq_err++;
        for (int k = 0; k < 3000 && started && !done; k++) begin
            i_dma_start = 1'b0;
            i_ce = ((cyc % ce_div) == 0);
            cyc++;
            if (i_ce) begin
                i_cpu_halted = (hcnt >= halt_wait) && !(halt_wait > 0 && idx >= 50 && idx < 53);
                hcnt++;
                if (!o_cpu_rdy) begin
                    seen_low = 1;
                    rdy_low++;
                    if (o_busy !== 1'b1) seq_err++;
                    if (!o_bus_request) no_req_low++;
                end else if (seen_low) begin
                    if (o_busy !== 1'b0 || o_bus_request !== 1'b0) seq_err++;
                    done = 1;
                end
                if (o_bus_request && exp_read) begin
                    if (o_bus_rw !== 1'b1 || o_bus_address !== {page, 8'(idx)} || par !== 1'b0) seq_err++;
                    if (idx == glitch_idx) begin
                        i_dma_start = 1'b1;
                        i_dma_page  = 8'h07;
                    end
                    exp_read = 0;
                end else if (o_bus_request) begin
                    if (o_bus_rw !== 1'b0 || o_bus_address !== 16'h2004 ||
                        o_bus_data !== mem_val({page, 8'(idx)})) seq_err++;
                    nbytes++;
                    if (idx == reset_idx) begin
                        #1 i_reset_n = 1'b0;
                        #1 rsnap = outs;
                        i_dma_start = 1'b0;
                        i_cpu_halted = 1'b1;
                        @(posedge i_clk);
                        @(negedge i_clk);
                        i_reset_n = 1'b1;
                        par = 1'b0;
                        return;
                    end
                    idx++;
                    exp_read = 1;
                end
            end
            if (!done) begin
                prev = outs;
                ce_now = i_ce;
                tick();
                if (!ce_now && outs !== prev) hold_err++;
            end
        end
        if (!done) seq_err++;
        i_ce = 1'b1;
        i_cpu_halted = 1'b1;
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        i_ce = 1'b1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        checks++; if (o_cpu_rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy got=%b exp=1", o_cpu_rdy); end
        checks++; if (o_bus_request !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", o_bus_request); end
        checks++; if (o_bus_address !== 16'h0000) begin failures++; $display("FAIL reset_addr got=%h exp=0000", o_bus_address); end
        checks++; if (o_bus_rw !== 1'b1) begin failures++; $display("FAIL reset_rw got=%b exp=1", o_bus_rw); end
        checks++; if (o_bus_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", o_bus_data); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        i_reset_n = 1'b1;
        par = 1'b0;
    endtask

    task automatic test_start_no_ce();
        i_ce = 1'b0; i_dma_start = 1'b1; i_dma_page = 8'h09;
        tick();
        i_dma_start = 1'b0; i_ce = 1'b1;
        tick(); tick();
        checks++; if (o_cpu_rdy !== 1'b1 || o_busy !== 1'b0) begin failures++;
            $display("FAIL start_no_ce rdy=%b busy=%b exp rdy=1 busy=0", o_cpu_rdy, o_busy); end
    endtask

    task automatic test_basic(input string nm, input logic [7:0] page, input logic want_par,
                              input int halt_wait, input int ce_div, input int glitch_idx,
                              input int exp_rdy_low, input int exp_no_req);
        int rl, nr, nb, se, he;
        logic [27:0] rs;
        run_xfer(page, want_par, halt_wait, ce_div, glitch_idx, -1, rl, nr, nb, se, he, rs);
        checks++; if (rl !== exp_rdy_low) begin failures++; $display("FAIL %s_rdy_low got=%0d exp=%0d", nm, rl, exp_rdy_low); end
        checks++; if (nr !== exp_no_req) begin failures++; $display("FAIL %s_no_req got=%0d exp=%0d", nm, nr, exp_no_req); end
        checks++; if (nb !== 256) begin failures++; $display("FAIL %s_bytes got=%0d exp=256", nm, nb); end
        checks++; if (se !== 0) begin failures++; $display("FAIL %s_sequence errors=%0d exp=0", nm, se); end
        checks++; if (he !== 0) begin failures++; $display("FAIL %s_hold errors=%0d exp=0", nm, he); end
    endtask

    task automatic test_reset_mid();
        int rl, nr, nb, se, he;
        logic [27:0] rs;
        run_xfer(8'h05, 1'b1, 0, 1, -1, 100, rl, nr, nb, se, he, rs);
        checks++; if (rs !== {1'b1, 1'b0, 16'h0000, 1'b1, 8'h00, 1'b0}) begin failures++;
            $display("FAIL reset_mid_outputs got=%h exp=%h", rs, {1'b1, 1'b0, 16'h0000, 1'b1, 8'h00, 1'b0}); end
        checks++; if (nb !== 101 || se !== 0) begin failures++;
            $display("FAIL reset_mid_prefix bytes=%0d errs=%0d exp bytes=101 errs=0", nb, se); end
        test_basic("after_reset", 8'h04, 1'b1, 0, 1, -1, 513, 1);
    endtask

    initial begin
        test_reset();
        test_start_no_ce();
        test_basic("get_aligned", 8'h02, 1'b1, 0, 1, -1, 513, 1);
        test_basic("align", 8'h02, 1'b0, 0, 1, -1, 514, 2);
        // three wait cycles push the decision onto parity 0, adding an ALIGN
        test_basic("halt_wait", 8'h02, 1'b1, 3, 1, -1, 517, 5);
        test_basic("restart_ignored", 8'h03, 1'b1, 0, 1, 10, 513, 1);
        test_reset_mid();
        test_basic("ce_third", 8'h02, 1'b1, 0, 3, -1, 513, 1);
        test_basic("page_ff", 8'hFF, 1'b0, 0, 1, -1, 514, 2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
